param_loader: RTL and testbench
===============================

PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 cmd_valid  input  1  command present.
REQ-004 cmd_ready  output  1  loader can accept a command this cycle.
REQ-005 cmd_addr  input  8  target parameter address on the profile generator parameter bus.
REQ-006 cmd_data  input  64  parameter value; [31:0] is the lo half, [63:32] is the hi half.
REQ-007 cmd_mask  input  2  bit0 = write lo half, bit1 = write hi half.
REQ-008 cmd_step  input  1  issue one acc_step pulse after this command's writes.
REQ-009 step_period  input  32  auto-step interval in clocks; 0 disables auto-step.
REQ-010 param_addr  output  8  parameter bus address.
REQ-011 param_in  output  32  parameter bus data.
REQ-012 param_write_lo  output  1  lo-half write strobe.
REQ-013 param_write_hi  output  1  hi-half write strobe.
REQ-014 acc_step  output  1  one-clock step pulse to the profile generator.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 step_count  output  16  count of acc_step pulses issued; wraps from 0xFFFF to 0.

Function
REQ-017 FSM states SHALL be IDLE, WR_LO, WR_HI, STEP; cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready.
REQ-018 All bus outputs (param_*, acc_step) SHALL be registered; the first bus action appears the cycle after acceptance.
REQ-019 Transition from IDLE on accept SHALL go to WR_LO if mask[0], else to WR_HI if mask[1], else to STEP if cmd_step, else stay in IDLE (no-op command consumed, no bus activity).
REQ-020 WR_LO SHALL drive param_addr=cmd_addr, param_in=data[31:0], param_write_lo=1 for exactly one cycle.
REQ-021 WR_HI SHALL drive param_addr=cmd_addr, param_in=data[63:32], param_write_hi=1 for exactly one cycle.
REQ-022 Merge rule: if mask=11 and data[63:32]==data[31:0], WR_LO SHALL assert both strobes in one cycle and skip WR_HI.
REQ-023 After WR_LO the FSM SHALL go to WR_HI if mask[1] and no merge, else STEP if cmd_step, else IDLE; after WR_HI it SHALL go to STEP if cmd_step, else IDLE; STEP SHALL pulse acc_step for one cycle and return to IDLE.
REQ-024 Strobes SHALL be 0 and param_in/param_addr SHALL hold their last driven values when no write is in progress.
REQ-025 Command fields SHALL be latched at acceptance; input changes afterwards SHALL have no effect.
REQ-026 step_count SHALL increment once per acc_step pulse, including merged pulses counted once.

Reset
REQ-027 On rst assertion, regardless of clock, the FSM SHALL enter IDLE; all outputs, the latched command, the auto-step counter and step_count SHALL be 0; cmd_ready SHALL be 1 from the first clock after rst deasserts.
REQ-028 A command in progress at reset SHALL be dropped with no further strobes.

Configuration
REQ-029 With PARAM_LOADER_AUTOSTEP_EN defined, a free-running counter SHALL pulse acc_step every step_period clocks while step_period != 0; a STEP-state pulse coinciding with an auto pulse SHALL yield one pulse and reload the counter; a change to step_period SHALL reload the counter.
REQ-030 Without PARAM_LOADER_AUTOSTEP_EN, step_period SHALL be ignored and acc_step SHALL come only from STEP.

Verification
REQ-031 Accept addr=0x03, data=0x00000007_00000003, mask=11 -> WR_LO cycle (param_in=3, lo=1) then WR_HI cycle (param_in=7, hi=1), acc_step stays 0, cmd_ready returns to 1 after 2 busy cycles.
REQ-032 Accept addr=0x20, data=0, mask=11 -> single cycle with both strobes and param_in=0, then IDLE.
REQ-033 Accept addr=0x05, mask=10, cmd_step=1 -> WR_HI only, then a one-clock acc_step, step_count goes 0 to 1.
REQ-034 Assert rst during the WR_LO cycle of a mask=11 command -> no hi strobe ever occurs, all outputs 0, cmd_ready=1 after release.
REQ-035 With PARAM_LOADER_AUTOSTEP_EN and step_period=100 -> acc_step pulses at 100-clock spacing; a cmd_step pulse coinciding with an auto pulse yields a single pulse and step_count increments by 1.
REQ-036 Accept mask=00, cmd_step=0 -> consumed, busy stays 0, no strobes.

Source files
------------

// File: rtl/param_loader.sv
// Parameter loader: turns 64-bit masked commands into lo/hi writes on the profile
// generator parameter bus, with optional step pulses (PARAM_LOADER_AUTOSTEP_EN adds auto-step).
module param_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [63:0] cmd_data,
    input  logic [1:0]  cmd_mask,
    input  logic        cmd_step,
    input  logic [31:0] step_period,
    output logic [7:0]  param_addr,
    output logic [31:0] param_in,
    output logic        param_write_lo,
    output logic        param_write_hi,
    output logic        acc_step,
    output logic        busy,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        alive_q;
    logic [7:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  mask_q, mask_d;
    logic        step_q, step_d;
    logic [7:0]  param_addr_q, param_addr_d;
    logic [31:0] param_in_q, param_in_d;
    logic        wr_lo_q, wr_lo_d;
    logic        wr_hi_q, wr_hi_d;
    logic        acc_step_q, acc_step_d;
    logic [15:0] step_count_q, step_count_d;
    logic        accept;
    logic        merge_now;
    logic        merge_lat;
    logic        step_pulse;
    logic        auto_hit;

    // Bus outputs are computed for the state being entered, so they appear while in it.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        step_d       = step_q;
        param_addr_d = param_addr_q;
        param_in_d   = param_in_q;
        wr_lo_d      = 1'b0;
        wr_hi_d      = 1'b0;
        step_pulse   = 1'b0;
        accept       = cmd_valid && cmd_ready;
        merge_now    = (cmd_mask == 2'b11) && (cmd_data[63:32] == cmd_data[31:0]);
        merge_lat    = (mask_q == 2'b11) && (data_q[63:32] == data_q[31:0]);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    mask_d = cmd_mask;
                    step_d = cmd_step;
                    if (cmd_mask[0]) begin
                        state_d      = WR_LO;
                        wr_lo_d      = 1'b1;
                        wr_hi_d      = merge_now;
                        param_addr_d = cmd_addr;
                        param_in_d   = cmd_data[31:0];
                    end else if (cmd_mask[1]) begin
                        state_d      = WR_HI;
                        wr_hi_d      = 1'b1;
                        param_addr_d = cmd_addr;
                        param_in_d   = cmd_data[63:32];
                    end else if (cmd_step) begin
                        state_d    = STEP;
                        step_pulse = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (mask_q[1] && !merge_lat) begin
                    state_d      = WR_HI;
                    wr_hi_d      = 1'b1;
                    param_addr_d = addr_q;
                    param_in_d   = data_q[63:32];
                end else if (step_q) begin
                    state_d    = STEP;
                    step_pulse = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI: begin
                if (step_q) begin
                    state_d    = STEP;
                    step_pulse = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        acc_step_d   = step_pulse || auto_hit;
        step_count_d = acc_step_d ? step_count_q + 16'd1 : step_count_q;
    end

`ifdef PARAM_LOADER_AUTOSTEP_EN
    logic [31:0] period_q, period_d;
    logic [31:0] auto_cnt_q, auto_cnt_d;
    logic        period_changed;

    // A hit reloads the counter, so a coinciding STEP pulse merges into one pulse.
    always_comb begin
        period_changed = (step_period != period_q);
        period_d       = step_period;
        auto_hit       = !period_changed && (step_period != 32'd0)
                         && (auto_cnt_q == step_period - 32'd1);
        auto_cnt_d     = (period_changed || auto_hit) ? 32'd0 : auto_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q   <= 32'd0;
            auto_cnt_q <= 32'd0;
        end else begin
            period_q   <= period_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic unused_step_period;
    assign unused_step_period = ^step_period;
    assign auto_hit           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alive_q      <= 1'b0;
            addr_q       <= 8'd0;
            data_q       <= 64'd0;
            mask_q       <= 2'd0;
            step_q       <= 1'b0;
            param_addr_q <= 8'd0;
            param_in_q   <= 32'd0;
            wr_lo_q      <= 1'b0;
            wr_hi_q      <= 1'b0;
            acc_step_q   <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            alive_q      <= 1'b1;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            step_q       <= step_d;
            param_addr_q <= param_addr_d;
            param_in_q   <= param_in_d;
            wr_lo_q      <= wr_lo_d;
            wr_hi_q      <= wr_hi_d;
            acc_step_q   <= acc_step_d;
            step_count_q <= step_count_d;
        end
    end

    // cmd_ready stays low through reset and rises on the first clock after release.
    assign cmd_ready      = alive_q && (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign param_addr     = param_addr_q;
    assign param_in       = param_in_q;
    assign param_write_lo = wr_lo_q;
    assign param_write_hi = wr_hi_q;
    assign acc_step       = acc_step_q;
    assign step_count     = step_count_q;

endmodule

// File: tb/tb_param_loader.sv
// Self-checking bench for param_loader: directed cases plus random commands against a
// transaction-level model of the expected bus events.
module tb_param_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [63:0] cmd_data;
    logic [1:0]  cmd_mask;
    logic        cmd_step;
    logic [31:0] step_period;
    logic [7:0]  param_addr;
    logic [31:0] param_in;
    logic        param_write_lo;
    logic        param_write_hi;
    logic        acc_step;
    logic        busy;
    logic [15:0] step_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_addr;
    logic [31:0] m_in;
    logic [15:0] m_count;

    typedef struct {
        bit          lo;
        bit          hi;
        bit          step;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_ev_t;

    param_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_mask       (cmd_mask),
        .cmd_step       (cmd_step),
        .step_period    (step_period),
        .param_addr     (param_addr),
        .param_in       (param_in),
        .param_write_lo (param_write_lo),
        .param_write_hi (param_write_hi),
        .acc_step       (acc_step),
        .busy           (busy),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, ".lo"},    64'(param_write_lo), 64'd0);
        check_output({tag, ".hi"},    64'(param_write_hi), 64'd0);
        check_output({tag, ".step"},  64'(acc_step),       64'd0);
        check_output({tag, ".busy"},  64'(busy),           64'd0);
        check_output({tag, ".ready"}, 64'(cmd_ready),      64'd1);
        check_output({tag, ".addr"},  64'(param_addr),     64'(m_addr));
        check_output({tag, ".in"},    64'(param_in),       64'(m_in));
        check_output({tag, ".count"}, 64'(step_count),     64'(m_count));
    endtask

    task automatic apply_stimulus(input string tag, input logic [7:0] a, input logic [63:0] d,
                                  input logic [1:0] m, input bit s);
        bus_ev_t evs[$];
        bit      merge;
        int      guard;
        logic [7:0]  exp_addr;
        logic [31:0] exp_in;
        merge = (m == 2'b11) && (d[63:32] == d[31:0]);
        if (m[0]) begin
            evs.push_back('{1'b1, merge, 1'b0, a, d[31:0]});
            if (m[1] && !merge) evs.push_back('{1'b0, 1'b1, 1'b0, a, d[63:32]});
        end else if (m[1]) begin
            evs.push_back('{1'b0, 1'b1, 1'b0, a, d[63:32]});
        end
        if (s) evs.push_back('{1'b0, 1'b0, 1'b1, 8'd0, 32'd0});

        guard = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        check_output({tag, ".ready_wait"}, 64'(cmd_ready), 64'd1);

        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_mask  = m;
        cmd_step  = s;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_data  = {$urandom, $urandom};
        cmd_mask  = 2'($urandom);
        cmd_step  = 1'($urandom);

        foreach (evs[i]) begin
            if (evs[i].lo || evs[i].hi) begin
                m_addr = evs[i].addr;
                m_in   = evs[i].data;
            end
            if (evs[i].step) m_count = m_count + 16'd1;
            exp_addr = m_addr;
            exp_in   = m_in;
            check_output({tag, ".ev.lo"},    64'(param_write_lo), 64'(evs[i].lo));
            check_output({tag, ".ev.hi"},    64'(param_write_hi), 64'(evs[i].hi));
            check_output({tag, ".ev.step"},  64'(acc_step),       64'(evs[i].step));
            check_output({tag, ".ev.addr"},  64'(param_addr),     64'(exp_addr));
            check_output({tag, ".ev.in"},    64'(param_in),       64'(exp_in));
            check_output({tag, ".ev.busy"},  64'(busy),           64'd1);
            check_output({tag, ".ev.ready"}, 64'(cmd_ready),      64'd0);
            check_output({tag, ".ev.count"}, 64'(step_count),     64'(m_count));
            tick();
        end
        check_idle({tag, ".after"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, ".addr"},  64'(param_addr),     64'd0);
        check_output({tag, ".in"},    64'(param_in),       64'd0);
        check_output({tag, ".lo"},    64'(param_write_lo), 64'd0);
        check_output({tag, ".hi"},    64'(param_write_hi), 64'd0);
        check_output({tag, ".step"},  64'(acc_step),       64'd0);
        check_output({tag, ".busy"},  64'(busy),           64'd0);
        check_output({tag, ".ready"}, 64'(cmd_ready),      64'd0);
        check_output({tag, ".count"}, 64'(step_count),     64'd0);
    endtask

    task automatic reset_during_write();
        bit saw_hi;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h44;
        cmd_data  = 64'hAAAA5555_12345678;
        cmd_mask  = 2'b11;
        cmd_step  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_output("rstwr.in_wr_lo", 64'(param_write_lo), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rstwr.during");
        tick();
        tick();
        rst = 1'b0;
        m_addr  = 8'd0;
        m_in    = 32'd0;
        m_count = 16'd0;
        saw_hi  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (param_write_hi) saw_hi = 1'b1;
            if (i == 0) check_idle("rstwr.release");
        end
        check_output("rstwr.no_hi", 64'(saw_hi), 64'd0);
    endtask

`ifdef PARAM_LOADER_AUTOSTEP_EN
    task automatic wait_pulse(input string tag, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!acc_step && gap < 400);
        check_output({tag, ".seen"}, 64'(acc_step), 64'd1);
    endtask

    task automatic autostep_test();
        int         gap;
        logic [15:0] c0;
        step_period = 32'd100;
        wait_pulse("auto.first", gap);
        wait_pulse("auto.gap1", gap);
        check_output("auto.gap1.len", 64'(gap), 64'd100);
        for (int i = 0; i < 99; i++) tick();
        check_output("auto.pre.step", 64'(acc_step), 64'd0);
        c0        = step_count;
        cmd_valid = 1'b1;
        cmd_mask  = 2'b00;
        cmd_step  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_output("auto.coin.step",  64'(acc_step),   64'd1);
        check_output("auto.coin.count", 64'(step_count), 64'(c0 + 16'd1));
        tick();
        check_output("auto.coin.single", 64'(acc_step), 64'd0);
        check_output("auto.coin.hold",   64'(step_count), 64'(c0 + 16'd1));
        gap = 1;
        while (!acc_step && gap < 400) begin
            tick();
            gap++;
        end
        check_output("auto.gap2.len", 64'(gap), 64'd100);
        step_period = 32'd0;
    endtask
`endif

    initial begin
        bit          s;
        logic [1:0]  m;
        logic [31:0] r;
        logic [63:0] d;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'd0;
        cmd_data  = 64'd0;
        cmd_mask  = 2'd0;
        cmd_step  = 1'b0;
`ifdef PARAM_LOADER_AUTOSTEP_EN
        step_period = 32'd0;
`else
        step_period = 32'd7;
`endif
        m_addr  = 8'd0;
        m_in    = 32'd0;
        m_count = 16'd0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle("reset.release");

        apply_stimulus("two_writes",  8'h03, 64'h00000007_00000003, 2'b11, 1'b0);
        apply_stimulus("merge_zero",  8'h20, 64'h0, 2'b11, 1'b0);
        apply_stimulus("hi_step",     8'h05, 64'h0BADF00D_CAFEF00D, 2'b10, 1'b1);
        apply_stimulus("noop",        8'h77, 64'h11111111_22222222, 2'b00, 1'b0);
        apply_stimulus("lo_step",     8'h09, 64'h33333333_44444444, 2'b01, 1'b1);
        apply_stimulus("merge_step",  8'hFE, 64'hDEADBEEF_DEADBEEF, 2'b11, 1'b1);
        apply_stimulus("step_only",   8'h12, 64'h0, 2'b00, 1'b1);
        reset_during_write();

        for (int n = 0; n < 150; n++) begin
`ifndef PARAM_LOADER_AUTOSTEP_EN
            step_period = $urandom;
`endif
            r = $urandom;
            d = ($urandom_range(0, 3) == 0) ? {r, r} : {$urandom, $urandom};
            m = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            apply_stimulus("rand", 8'($urandom), d, m, s);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check_idle("rand.gap");
            end
        end

`ifdef PARAM_LOADER_AUTOSTEP_EN
        autostep_test();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
